// File: rtl/uv_iomux_ctrl.sv
// uv_iomux_ctrl: per-pad function mux with guarded select changes and pad-input synchronisers
module uv_iomux_ctrl #(
  parameter int IO_NUM = 32,
  parameter int FUNC_NUM = 4,
  parameter int SEL_W = 2,
  parameter int ADDR_W = 5,
  parameter int GUARD_CYC = 4,
  parameter int SYNC_STAGES = 2,
  parameter logic [IO_NUM*SEL_W-1:0] RST_SEL = '0,
  parameter logic [FUNC_NUM-1:0] IN_IDLE = '0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic force_gpio_i,
  input  logic cfg_req_i,
  input  logic cfg_we_i,
  input  logic [ADDR_W-1:0] cfg_addr_i,
  input  logic [SEL_W-1:0] cfg_wdata_i,
  output logic cfg_ack_o,
  output logic cfg_err_o,
  output logic [SEL_W-1:0] cfg_rdata_o,
  input  logic [FUNC_NUM*IO_NUM-1:0] func_pu_i,
  input  logic [FUNC_NUM*IO_NUM-1:0] func_pd_i,
  input  logic [FUNC_NUM*IO_NUM-1:0] func_ie_i,
  input  logic [FUNC_NUM*IO_NUM-1:0] func_oe_i,
  input  logic [FUNC_NUM*IO_NUM-1:0] func_out_i,
  output logic [FUNC_NUM*IO_NUM-1:0] func_in_o,
  output logic [IO_NUM-1:0] pad_pu_o,
  output logic [IO_NUM-1:0] pad_pd_o,
  output logic [IO_NUM-1:0] pad_ie_o,
  output logic [IO_NUM-1:0] pad_oe_o,
  output logic [IO_NUM-1:0] pad_out_o,
  input  logic [IO_NUM-1:0] pad_in_i
);
  localparam int CNT_W = $clog2(GUARD_CYC + 1);
  localparam logic [1:0] IDLE = 2'd0, GUARD = 2'd1, ACK = 2'd2;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] pin_q, pin_d;
  logic [SEL_W-1:0] nsel_q, nsel_d, rdata_q, rdata_d, cur_sel;
  logic err_q, err_d, bad, commit;
  logic [SEL_W-1:0] sel_q [IO_NUM];
  logic [SEL_W-1:0] eff [IO_NUM];
  logic [IO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IO_NUM-1:0] gd;

  always_comb begin
    cur_sel = '0;
    for (int i = 0; i < IO_NUM; i++) if (int'(cfg_addr_i) == i) cur_sel = sel_q[i];
  end

  assign bad = int'(cfg_addr_i) >= IO_NUM || (cfg_we_i && int'(cfg_wdata_i) >= FUNC_NUM);

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pin_d = pin_q;
    nsel_d = nsel_q;
    err_d = err_q;
    rdata_d = rdata_q;
    commit = 1'b0;
    if (state_q == IDLE && cfg_req_i) begin
      pin_d = cfg_addr_i;
      nsel_d = cfg_wdata_i;
      err_d = bad;
      rdata_d = bad ? '0 : cur_sel;
      cnt_d = CNT_W'(GUARD_CYC - 1);
      state_d = (cfg_we_i && !bad && cfg_wdata_i != cur_sel) ? GUARD : ACK;
    end else if (state_q == GUARD) begin
      commit = cnt_q == '0;
      cnt_d = commit ? cnt_q : cnt_q - 1'b1;
      rdata_d = commit ? nsel_q : rdata_q;
      state_d = commit ? ACK : GUARD;
    end else if (state_q == ACK) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q <= '0;
      pin_q <= '0;
      nsel_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
      for (int i = 0; i < IO_NUM; i++) sel_q[i] <= RST_SEL[i*SEL_W +: SEL_W];
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pin_q <= pin_d;
      nsel_q <= nsel_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
      for (int i = 0; i < IO_NUM; i++) if (commit && int'(pin_q) == i) sel_q[i] <= nsel_q;
      sync_q[0] <= pad_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign cfg_ack_o = state_q == ACK;
  assign cfg_err_o = cfg_ack_o & err_q;
  assign cfg_rdata_o = cfg_ack_o ? rdata_q : '0;

  // force_gpio overrides both the stored select and the guard
  always_comb begin
    for (int i = 0; i < IO_NUM; i++) begin
      eff[i] = force_gpio_i ? '0 : sel_q[i];
      gd[i] = !force_gpio_i && state_q == GUARD && int'(pin_q) == i;
    end
  end

  always_comb begin
    pad_pu_o = '0;
    pad_pd_o = '0;
    pad_ie_o = '0;
    pad_oe_o = '0;
    pad_out_o = '0;
    func_in_o = '0;
    for (int i = 0; i < IO_NUM; i++) begin
      for (int f = 0; f < FUNC_NUM; f++) begin
        if (int'(eff[i]) == f && !gd[i]) begin
          pad_pu_o[i] = func_pu_i[f*IO_NUM+i];
          pad_pd_o[i] = func_pd_i[f*IO_NUM+i];
          pad_ie_o[i] = func_ie_i[f*IO_NUM+i];
          pad_oe_o[i] = func_oe_i[f*IO_NUM+i];
          pad_out_o[i] = func_out_i[f*IO_NUM+i];
          func_in_o[f*IO_NUM+i] = sync_q[SYNC_STAGES-1][i];
        end else begin
          func_in_o[f*IO_NUM+i] = IN_IDLE[f];
        end
      end
    end
  end
endmodule

// File: tb/tb_uv_iomux_ctrl.sv
// tb_uv_iomux_ctrl: randomized self-checking bench for uv_iomux_ctrl against a pin-level reference model
module tb_uv_iomux_ctrl;
  localparam int IO = 32, FN = 3, GC = 4;
  localparam logic [2:0] IDLE_V = 3'b010;
  logic clk = 0, rst_n = 0, force_gpio = 0, cfg_req = 0, cfg_we = 0;
  logic [5:0] cfg_addr = '0;
  logic [1:0] cfg_wdata = '0, cfg_rdata;
  logic cfg_ack, cfg_err;
  logic [FN*IO-1:0] func_pu = '0, func_pd = '0, func_ie = '0, func_oe = '0, func_out = '0, func_in;
  logic [IO-1:0] pad_pu, pad_pd, pad_ie, pad_oe, pad_out, pad_in = '0;
  int errors = 0, checks = 0;
  int msel [IO];
  int gpin = -1;

  uv_iomux_ctrl #(.IO_NUM(IO), .FUNC_NUM(FN), .SEL_W(2), .ADDR_W(6), .GUARD_CYC(GC),
    .SYNC_STAGES(2), .RST_SEL('0), .IN_IDLE(IDLE_V)) dut (
    .clk_i(clk), .rst_ni(rst_n), .force_gpio_i(force_gpio), .cfg_req_i(cfg_req), .cfg_we_i(cfg_we),
    .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata), .cfg_ack_o(cfg_ack), .cfg_err_o(cfg_err),
    .cfg_rdata_o(cfg_rdata), .func_pu_i(func_pu), .func_pd_i(func_pd), .func_ie_i(func_ie),
    .func_oe_i(func_oe), .func_out_i(func_out), .func_in_o(func_in), .pad_pu_o(pad_pu),
    .pad_pd_o(pad_pd), .pad_ie_o(pad_ie), .pad_oe_o(pad_oe), .pad_out_o(pad_out), .pad_in_i(pad_in));

  always #5 clk = ~clk;

  // expected {pu,pd,ie,oe,out}: forced pins use function 0, a guarded pin is all-zero
  function automatic logic [5*IO-1:0] m_pads();
    logic [5*IO-1:0] r;
    int e;
    bit g;
    for (int i = 0; i < IO; i++) begin
      e = force_gpio ? 0 : msel[i];
      g = !force_gpio && i == gpin;
      r[4*IO+i] = g ? 1'b0 : func_pu[e*IO+i];
      r[3*IO+i] = g ? 1'b0 : func_pd[e*IO+i];
      r[2*IO+i] = g ? 1'b0 : func_ie[e*IO+i];
      r[IO+i] = g ? 1'b0 : func_oe[e*IO+i];
      r[i] = g ? 1'b0 : func_out[e*IO+i];
    end
    return r;
  endfunction

  function automatic logic [FN*IO-1:0] m_fin(input logic [IO-1:0] sin);
    logic [FN*IO-1:0] r;
    int e;
    for (int i = 0; i < IO; i++) begin
      e = force_gpio ? 0 : msel[i];
      for (int f = 0; f < FN; f++)
        r[f*IO+i] = (e == f && !(!force_gpio && i == gpin)) ? sin[i] : IDLE_V[f];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_funcs();
    func_pu = {$urandom, $urandom, $urandom};
    func_pd = {$urandom, $urandom, $urandom};
    func_ie = {$urandom, $urandom, $urandom};
    func_oe = {$urandom, $urandom, $urandom};
    func_out = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_cfg(input logic we, input int addr, input int wd, output int lat,
                        output logic err, output logic [1:0] rd);
    tick();
    cfg_req = 1; cfg_we = we; cfg_addr = 6'(addr); cfg_wdata = 2'(wd);
    lat = -1; err = 0; rd = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (cfg_ack) begin
        lat = n; err = cfg_err; rd = cfg_rdata;
        break;
      end
    end
    cfg_req = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    rand_funcs();
    pad_in = $urandom;
    tick(); tick();
    checks++;
    if (cfg_ack !== 1'b0 || cfg_err !== 1'b0 || cfg_rdata !== 2'b0) begin
      errors++; $display("FAIL reset_cfg got ack=%b err=%b rdata=%0d want 0/0/0", cfg_ack, cfg_err, cfg_rdata);
    end
    checks++;
    if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads()) begin
      errors++; $display("FAIL reset_pads got %h want %h", {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, m_pads());
    end
    checks++;
    if (func_in !== m_fin('0)) begin
      errors++; $display("FAIL reset_func_in got %h want %h", func_in, m_fin('0));
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_write_guard();
    rand_funcs();
    func_oe[2*IO+3] = 1; func_out[2*IO+3] = 1;
    pad_in = $urandom;
    tick(); tick();
    cfg_req = 1; cfg_we = 1; cfg_addr = 6'd3; cfg_wdata = 2'd2;
    for (int n = 1; n <= GC + 1; n++) begin
      tick();
      gpin = (n <= GC) ? 3 : -1;
      if (n == GC + 1) msel[3] = 2;
      checks++;
      if (cfg_ack !== (n == GC + 1)) begin
        errors++; $display("FAIL guard_ack cycle %0d got %b want %b", n, cfg_ack, n == GC + 1);
      end
      checks++;
      if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads()) begin
        errors++; $display("FAIL guard_pads cycle %0d got %h want %h", n, {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, m_pads());
      end
      checks++;
      if (func_in !== m_fin(pad_in)) begin
        errors++; $display("FAIL guard_func_in cycle %0d got %h want %h", n, func_in, m_fin(pad_in));
      end
    end
    checks++;
    if (cfg_err !== 1'b0 || cfg_rdata !== 2'd2 || pad_oe[3] !== 1'b1 || pad_out[3] !== 1'b1) begin
      errors++; $display("FAIL guard_commit got err=%b rdata=%0d oe=%b out=%b want 0/2/1/1", cfg_err, cfg_rdata, pad_oe[3], pad_out[3]);
    end
    cfg_req = 0;
  endtask

  task automatic test_same_write();
    int lat;
    logic err;
    logic [1:0] rd;
    do_cfg(1, 3, 2, lat, err, rd);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 2'd2 || pad_oe !== m_pads()[IO +: IO]) begin
      errors++; $display("FAIL same_write got lat=%0d err=%b rdata=%0d oe=%h want 1/0/2/%h", lat, err, rd, pad_oe, m_pads()[IO +: IO]);
    end
    do_cfg(0, 3, 0, lat, err, rd);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 2'd2) begin
      errors++; $display("FAIL read_pin3 got lat=%0d err=%b rdata=%0d want 1/0/2", lat, err, rd);
    end
  endtask

  task automatic test_errors();
    int lat;
    logic err;
    logic [1:0] rd;
    do_cfg(1, 40, 1, lat, err, rd);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 2'd0) begin
      errors++; $display("FAIL err_pin40 got lat=%0d err=%b rdata=%0d want 1/1/0", lat, err, rd);
    end
    do_cfg(1, 7, 3, lat, err, rd);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 2'd0) begin
      errors++; $display("FAIL err_sel3 got lat=%0d err=%b rdata=%0d want 1/1/0", lat, err, rd);
    end
    do_cfg(1, 3, 3, lat, err, rd);
    checks++;
    if (lat !== 1 || err !== 1'b1 || rd !== 2'd0) begin
      errors++; $display("FAIL err_sel3_pin3 got lat=%0d err=%b rdata=%0d want 1/1/0", lat, err, rd);
    end
    do_cfg(0, 3, 0, lat, err, rd);
    checks++;
    if (rd !== 2'd2 || err !== 1'b0) begin
      errors++; $display("FAIL err_unchanged got rdata=%0d err=%b want 2/0", rd, err);
    end
    checks++;
    if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads()) begin
      errors++; $display("FAIL err_pads got %h want %h", {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, m_pads());
    end
  endtask

  task automatic test_sync();
    int lat;
    logic err;
    logic [1:0] rd;
    do_cfg(1, 5, 1, lat, err, rd);
    msel[5] = 1;
    checks++;
    if (lat !== GC + 1 || err !== 1'b0 || rd !== 2'd1) begin
      errors++; $display("FAIL sync_setup got lat=%0d err=%b rdata=%0d want %0d/0/1", lat, err, rd, GC + 1);
    end
    pad_in[5] = 0;
    tick(); tick(); tick();
    pad_in[5] = 1;
    for (int n = 1; n <= 2; n++) begin
      tick();
      checks++;
      if (func_in[IO+5] !== (n == 2) || func_in[5] !== IDLE_V[0]) begin
        errors++; $display("FAIL sync_latency cycle %0d got f1=%b f0=%b want %b/%b", n, func_in[IO+5], func_in[5], n == 2, IDLE_V[0]);
      end
    end
  endtask

  task automatic test_force_guard();
    rand_funcs();
    tick();
    cfg_req = 1; cfg_we = 1; cfg_addr = 6'd9; cfg_wdata = 2'd1;
    for (int n = 1; n <= GC + 1; n++) begin
      tick();
      gpin = (n <= GC) ? 9 : -1;
      if (n == GC + 1) msel[9] = 1;
      checks++;
      if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads() || cfg_ack !== (n == GC + 1)) begin
        errors++; $display("FAIL force_guard cycle %0d got %h ack=%b want %h", n, {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, cfg_ack, m_pads());
      end
      if (n == 2) force_gpio = 1;
      if (n == 2) begin
        #1;
        checks++;
        if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads()) begin
          errors++; $display("FAIL force_immediate got %h want %h", {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, m_pads());
        end
      end
    end
    checks++;
    if (cfg_rdata !== 2'd1) begin
      errors++; $display("FAIL force_commit got rdata=%0d want 1", cfg_rdata);
    end
    cfg_req = 0;
    force_gpio = 0;
    #1;
    checks++;
    if (pad_oe[9] !== func_oe[IO+9] || pad_out[9] !== func_out[IO+9]) begin
      errors++; $display("FAIL force_release got oe=%b out=%b want %b/%b", pad_oe[9], pad_out[9], func_oe[IO+9], func_out[IO+9]);
    end
  endtask

  task automatic test_random();
    int lat, a, wd, elat, erd;
    logic err, we, eerr;
    logic [1:0] rd;
    for (int k = 0; k < 40; k++) begin
      rand_funcs();
      pad_in = $urandom;
      force_gpio = 1'($urandom);
      tick();
      a = $urandom_range(39, 0);
      wd = $urandom_range(3, 0);
      we = 1'($urandom);
      eerr = a >= IO || (we && wd >= FN);
      elat = (!eerr && we && wd != msel[a]) ? GC + 1 : 1;
      erd = eerr ? 0 : (we ? wd : msel[a]);
      do_cfg(we, a, wd, lat, err, rd);
      if (!eerr && we) msel[a] = wd;
      checks++;
      if (lat !== elat || err !== eerr || rd !== 2'(erd)) begin
        errors++; $display("FAIL rand_cfg #%0d we=%b a=%0d wd=%0d got lat=%0d err=%b rd=%0d want %0d/%b/%0d", k, we, a, wd, lat, err, rd, elat, eerr, erd);
      end
      checks++;
      if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads() || func_in !== m_fin(pad_in)) begin
        errors++; $display("FAIL rand_pads #%0d got %h / %h want %h / %h", k, {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, func_in, m_pads(), m_fin(pad_in));
      end
    end
    force_gpio = 0;
  endtask

  task automatic test_reset_guard();
    bit seen;
    rand_funcs();
    tick();
    cfg_req = 1; cfg_we = 1; cfg_addr = 6'd12; cfg_wdata = 2'(msel[12] == 2 ? 1 : 2);
    tick(); tick();
    rst_n = 0; cfg_req = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < IO; i++) msel[i] = 0;
    gpin = -1;
    seen = 0;
    for (int n = 0; n < GC + 3; n++) begin
      if (cfg_ack) seen = 1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_guard_ack got ack=1 want 0");
    end
    checks++;
    if ({pad_pu, pad_pd, pad_ie, pad_oe, pad_out} !== m_pads()) begin
      errors++; $display("FAIL reset_guard_pads got %h want %h", {pad_pu, pad_pd, pad_ie, pad_oe, pad_out}, m_pads());
    end
    force_gpio = 1;
    #1;
    checks++;
    if ({pad_oe, pad_out} !== {func_oe[IO-1:0], func_out[IO-1:0]}) begin
      errors++; $display("FAIL reset_guard_force got %h want %h", {pad_oe, pad_out}, {func_oe[IO-1:0], func_out[IO-1:0]});
    end
    force_gpio = 0;
  endtask

  initial begin
    for (int i = 0; i < IO; i++) msel[i] = 0;
    test_reset();
    test_write_guard();
    test_same_write();
    test_errors();
    test_sync();
    test_force_guard();
    test_random();
    test_reset_guard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
